// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control and MUL/DIV occupancy sequencing for the 5-stage core
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mdu_start,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wr,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wr,
  input  logic             br_taken,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MDU_BUSY} state_t;
  state_t state, state_nx;
  logic [3:0] lat;
  logic load_use, run, busy, last, br_f, start, lu, hold;
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == RUN && !br_taken && ex_mdu_start) state_nx = MDU_BUSY;
    if (state == MDU_BUSY && lat == 4'd0) state_nx = RUN;
  end
  always_comb begin
    load_use = ex_is_load && ex_rd != 5'd0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    run = reset && state == RUN;
    busy = reset && state == MDU_BUSY;
    last = busy && lat == 4'd0;
    br_f = run && br_taken;
    start = run && !br_taken && ex_mdu_start;
    lu = run && !br_taken && !ex_mdu_start && load_use;
    hold = start || (busy && !last);
    stall_pc = hold || lu;
    stall_if_id = hold || lu;
    stall_id_ex = hold;
    bubble_ex_mem = hold;
    flush_if_id = br_f;
    flush_id_ex = br_f || lu;
    mdu_busy = busy;
    mdu_done = last;
    fwd_a = !reset ? 2'b00 :
            (mem_reg_wr && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
            (wb_reg_wr && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
    fwd_b = !reset ? 2'b00 :
            (mem_reg_wr && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
            (wb_reg_wr && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!reset) lat <= 4'd0;
    else if (start) lat <= 4'(MDU_LAT - 2);
    else if (busy && lat != 4'd0) lat <= lat - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_f && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, load-use, branch priority, MDU sequencing, reset and saturation
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_mdu_start, mem_reg_wr, wb_reg_wr, br_taken;
  logic stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble_ex_mem;
  logic [1:0] fwd_a, fwd_b;
  logic mdu_busy, mdu_done;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mdu_start(ex_mdu_start),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .br_taken(br_taken), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packed control word: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble, busy, done}
  function automatic logic [7:0] ctl();
    return {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble_ex_mem, mdu_busy, mdu_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_is_load, ex_mdu_start, mem_reg_wr, wb_reg_wr, br_taken} = '0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1; br_taken = 1'b1; ex_mdu_start = 1'b1;
    tick();
    chk("reset_ctl", 32'(ctl()), 32'h00);
    chk("reset_fwd_a", 32'(fwd_a), 32'h0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'h0);
    idle();
    reset = 1'b1;
    tick();
    chk("idle_ctl", 32'(ctl()), 32'h00);

    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1; wb_rd = 5'd5; wb_reg_wr = 1'b1;
    #1 chk("fwd_a_mem_prio", 32'(fwd_a), 32'h2);
    mem_reg_wr = 1'b0;
    #1 chk("fwd_a_wb", 32'(fwd_a), 32'h1);
    ex_rs2 = 5'd5;
    #1 chk("fwd_b_wb", 32'(fwd_b), 32'h1);
    ex_rs2 = 5'd0; mem_rd = 5'd0; mem_reg_wr = 1'b1; wb_rd = 5'd0;
    #1 chk("fwd_b_x0", 32'(fwd_b), 32'h0);
    idle();

    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1 chk("load_use_ctl", 32'(ctl()), 32'hC8);
    tick();
    chk("load_use_cnt", 32'(stall_cnt), 32'h1);
    ex_is_load = 1'b0;
    #1 chk("load_moved_ctl", 32'(ctl()), 32'h00);
    ex_is_load = 1'b1; id_use_rs2 = 1'b0;
    #1 chk("no_use_ctl", 32'(ctl()), 32'h00);
    tick();
    chk("no_use_cnt", 32'(stall_cnt), 32'h1);

    id_use_rs2 = 1'b1; br_taken = 1'b1;
    #1 chk("br_vs_lu_ctl", 32'(ctl()), 32'h18);
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'h1);
    idle();

    ex_mdu_start = 1'b1;
    #1 chk("mdu_c0", 32'(ctl()), 32'hE4);
    tick();
    ex_mdu_start = 1'b0;
    #1 chk("mdu_c1", 32'(ctl()), 32'hE6);
    tick();
    br_taken = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    #1 chk("mdu_c2_br_ignored", 32'(ctl()), 32'hE6);
    tick();
    idle();
    chk("mdu_c2_flush_cnt", 32'(flush_cnt), 32'h1);
    #1 chk("mdu_c3_done", 32'(ctl()), 32'h03);
    tick();
    chk("mdu_c4_run", 32'(ctl()), 32'h00);
    chk("mdu_stall_cnt", 32'(stall_cnt), 32'h4);

    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    tick();
    chk("mdu2_c2_busy", 32'(ctl()), 32'hE6);
    reset = 1'b0;
    #1 chk("mid_reset_ctl", 32'(ctl()), 32'h00);
    tick();
    reset = 1'b1;
    #1 chk("after_reset_ctl", 32'(ctl()), 32'h00);
    chk("after_reset_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("after_reset_flush_cnt", 32'(flush_cnt), 32'h0);

    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hF);
    idle();
    br_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("flush_cnt_sat", 32'(flush_cnt), 32'hF);
    chk("stall_cnt_held", 32'(stall_cnt), 32'hF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
